// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a one-entry skid buffer for MemoryUnit stalls.
// The skid only fills while main holds a valid word, so skid_valid implies main_valid.
module ex_mem_pipe #(
  parameter int WIDTH = 75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_word,
  output logic             ex_ready,
  input  logic             Stall_Signal,
  input  logic             flush,
  input  logic             stat_clr,
  output logic [WIDTH-1:0] EX_MEM_output,
  output logic             mem_valid,
  output logic [15:0]      stall_count
);

  logic             main_valid;
  logic [WIDTH-1:0] main_word;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_word;
  logic             hold;
  logic             accept;

  // A bubble in main is always replaced, whatever Stall_Signal says.
  assign hold   = Stall_Signal & main_valid;
  assign accept = ex_valid & ~skid_valid;

  assign ex_ready      = ~skid_valid;
  assign mem_valid     = main_valid;
  assign EX_MEM_output = main_valid ? main_word : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_word  <= '0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
    end else if (flush) begin
      // main is older than the redirect; only the younger skid entry and EX word die.
      skid_valid <= 1'b0;
      if (!hold) begin
        main_valid <= 1'b0;
        main_word  <= '0;
      end
    end else if (!hold) begin
      skid_valid <= 1'b0;
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_word  <= skid_word;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_word  <= ex_word;
      end else begin
        main_valid <= 1'b0;
        main_word  <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_word  <= ex_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stat_clr) begin
      stall_count <= '0;
    end else if (hold && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed vector table, reset/counter
// sequences, and random traffic against a queue-based reference model.
module tb_ex_mem_pipe;
  localparam int W = 75;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid;
  logic [W-1:0] ex_word;
  logic         ex_ready;
  logic         Stall_Signal;
  logic         flush;
  logic         stat_clr;
  logic [W-1:0] EX_MEM_output;
  logic         mem_valid;
  logic [15:0]  stall_count;

  int n_chk  = 0;
  int n_pass = 0;

  ex_mem_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_word(ex_word), .ex_ready(ex_ready),
    .Stall_Signal(Stall_Signal), .flush(flush), .stat_clr(stat_clr),
    .EX_MEM_output(EX_MEM_output), .mem_valid(mem_valid), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [31:0] data, input logic [2:0] dst,
                                      input logic mr, input logic mw, input logic wb,
                                      input logic [31:0] addr, input logic jwsp,
                                      input logic spc, input logic sflags,
                                      input logic isstk, input logic stkop);
    return {data, dst, mr, mw, wb, addr, jwsp, spc, sflags, isstk, stkop};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         stall;
    logic         fl;
    logic         v;
    logic [W-1:0] word;
    logic [W-1:0] e_out;
    logic         e_mv;
    logic         e_rdy;
    logic [15:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  logic [W-1:0] w1, w2, w3, wc, wp, wq, wi, wpop;

  // Reference model: in-flight words as an ordered queue (head = word in MEM).
  logic [W-1:0] mq[$];
  logic [15:0]  mcnt;

  task automatic model_edge(input logic st, input logic fl, input logic clr,
                            input logic v, input logic [W-1:0] wd, output logic took);
    logic h;
    h    = st && (mq.size() > 0);
    took = 1'b0;
    if (clr) mcnt = 16'd0;
    else if (h && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    if (fl) begin
      if (h) begin
        while (mq.size() > 1) void'(mq.pop_back());
      end else begin
        mq.delete();
      end
    end else begin
      if (!h && mq.size() > 0) void'(mq.pop_front());
      if (v && (h ? mq.size() < 2 : mq.size() < 1)) begin
        mq.push_back(wd);
        took = 1'b1;
      end
    end
  endtask

  initial begin
    logic took;
    logic pend_v;
    logic [W-1:0] pend_w;
    logic lim_ready;

    rst = 1'b1; ex_valid = 0; ex_word = '0; Stall_Signal = 0; flush = 0; stat_clr = 0;
    w1   = mk(32'd3, 3'd1, 0, 1, 0, 32'd15, 0, 0, 0, 0, 0);
    w2   = mk(32'd3, 3'd2, 0, 1, 0, 32'd15, 0, 0, 0, 0, 0);
    w3   = mk(32'd3, 3'd3, 0, 1, 0, 32'd15, 0, 0, 0, 0, 0);
    wc   = mk(32'd15, 3'd0, 0, 1, 0, 32'h100, 0, 1, 0, 0, 0);
    wp   = mk(32'd4, 3'd0, 0, 1, 0, 32'h0FF, 0, 0, 0, 1, 0);
    wq   = mk(32'h55, 3'd5, 0, 0, 1, 32'h20, 0, 0, 0, 0, 0);
    wi   = mk(32'h77, 3'd0, 0, 1, 0, 32'h3FE, 1, 1, 1, 0, 0);
    wpop = mk(32'h0, 3'd4, 1, 0, 1, 32'h3FE, 0, 0, 0, 1, 1);
    #1;
    chk("reset_out", EX_MEM_output, '0);
    chk("reset_mv", W'(mem_valid), W'(1'b0));
    chk("reset_rdy", W'(ex_ready), W'(1'b1));
    chk("reset_cnt", W'(stall_count), W'(16'd0));
    tick();
    rst = 1'b0;

    //              stall fl v word | out   mv rdy cnt
    vt.push_back('{0, 0, 1, w1,   w1,   1, 1, 0}); // streaming
    vt.push_back('{0, 0, 1, w2,   w2,   1, 1, 0});
    vt.push_back('{0, 0, 1, w3,   w3,   1, 1, 0});
    vt.push_back('{0, 0, 0, '0,   '0,   0, 1, 0});
    vt.push_back('{0, 0, 1, wc,   wc,   1, 1, 0}); // CALL stall, push into skid
    vt.push_back('{1, 0, 1, wp,   wc,   1, 0, 1});
    vt.push_back('{1, 0, 1, wq,   wc,   1, 0, 2});
    vt.push_back('{1, 0, 1, wq,   wc,   1, 0, 3});
    vt.push_back('{0, 0, 1, wq,   wp,   1, 1, 3});
    vt.push_back('{0, 0, 1, wq,   wq,   1, 1, 3});
    vt.push_back('{0, 0, 1, wi,   wi,   1, 1, 3}); // flush during INT stall
    vt.push_back('{1, 0, 1, wpop, wi,   1, 0, 4});
    vt.push_back('{1, 1, 0, '0,   wi,   1, 1, 5});
    vt.push_back('{1, 0, 0, '0,   wi,   1, 1, 6});
    vt.push_back('{0, 0, 0, '0,   '0,   0, 1, 6});
    vt.push_back('{0, 0, 1, w1,   w1,   1, 1, 6}); // flush without stall
    vt.push_back('{0, 1, 1, w2,   '0,   0, 1, 6});
    vt.push_back('{0, 0, 0, '0,   '0,   0, 1, 6});
    vt.push_back('{0, 0, 1, w1,   w1,   1, 1, 6}); // flush with stall release, skid full
    vt.push_back('{1, 0, 1, w2,   w1,   1, 0, 7});
    vt.push_back('{0, 1, 1, w3,   '0,   0, 1, 7});
    vt.push_back('{1, 0, 1, w3,   w3,   1, 1, 7}); // stall on a bubble is ignored
    vt.push_back('{0, 0, 0, '0,   '0,   0, 1, 7});

    foreach (vt[i]) begin
      Stall_Signal = vt[i].stall; flush = vt[i].fl; ex_valid = vt[i].v; ex_word = vt[i].word;
      tick();
      chk($sformatf("vec%0d_out", i), EX_MEM_output, vt[i].e_out);
      chk($sformatf("vec%0d_mv", i), W'(mem_valid), W'(vt[i].e_mv));
      chk($sformatf("vec%0d_rdy", i), W'(ex_ready), W'(vt[i].e_rdy));
      chk($sformatf("vec%0d_cnt", i), W'(stall_count), W'(vt[i].e_cnt));
    end
    Stall_Signal = 0; flush = 0; ex_valid = 0;

    // Asynchronous reset mid-cycle with main and skid both full.
    ex_valid = 1; ex_word = w1; tick();
    Stall_Signal = 1; ex_word = w2; tick();
    ex_valid = 0;
    chk("pre_rst_rdy", W'(ex_ready), W'(1'b0));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", EX_MEM_output, '0);
    chk("async_rst_mv", W'(mem_valid), W'(1'b0));
    chk("async_rst_rdy", W'(ex_ready), W'(1'b1));
    chk("async_rst_cnt", W'(stall_count), W'(16'd0));
    tick();
    rst = 1'b0; Stall_Signal = 0;
    tick();
    chk("post_rst_mv", W'(mem_valid), W'(1'b0));

    // Counter saturation, clear priority, no count on a bubble.
    ex_valid = 1; ex_word = w3; tick();
    ex_valid = 0; Stall_Signal = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_fffe", W'(stall_count), W'(16'hFFFE));
    tick();
    chk("cnt_ffff", W'(stall_count), W'(16'hFFFF));
    repeat (4465) @(posedge clk);
    #1;
    chk("cnt_sat", W'(stall_count), W'(16'hFFFF));
    chk("cnt_hold_out", EX_MEM_output, w3);
    stat_clr = 1; tick();
    chk("cnt_clr", W'(stall_count), W'(16'd0));
    stat_clr = 0; Stall_Signal = 0; tick();
    chk("cnt_drain_mv", W'(mem_valid), W'(1'b0));
    Stall_Signal = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_bubble", W'(stall_count), W'(16'd0));
    Stall_Signal = 0;

    // Random traffic against the queue model.
    do_reset();
    mq.delete(); mcnt = 16'd0;
    pend_v = 0; pend_w = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1;
        pend_w = {$urandom(), $urandom(), 11'($urandom())};
      end
      Stall_Signal = ($urandom_range(0, 9) < 4);
      flush        = ($urandom_range(0, 19) == 0);
      stat_clr     = ($urandom_range(0, 49) == 0);
      ex_valid     = pend_v;
      ex_word      = pend_v ? pend_w : W'({$urandom(), $urandom()});
      model_edge(Stall_Signal, flush, stat_clr, pend_v, pend_w, took);
      if (took || flush) pend_v = 0;
      tick();
      lim_ready = (mq.size() < 2);
      chk("rnd_out", EX_MEM_output, (mq.size() > 0) ? mq[0] : '0);
      chk("rnd_mv", W'(mem_valid), W'(mq.size() > 0));
      chk("rnd_rdy", W'(ex_ready), W'(lim_ready));
      chk("rnd_cnt", W'(stall_count), W'(mcnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 2000000);
    $fatal(1);
  end

endmodule
